apple2_kbd_latch: RTL and testbench
===================================

// Module: apple2_kbd_latch
// PURPOSE
// - Downstream of the AY-3600 keyboard encoder. Holds the 7-bit ASCII keycode and the keyboard strobe flag.
// - Presents them to the 6502 bus at $C000-$C00F (KBD) and $C010-$C01F (KBDSTRB, strobe clear).
// - Adds Apple IIe-style auto-repeat while a key is held: an initial delay, then a fixed repeat period.
// PARAMETERS
// - TICKS_PER_MS  50000  Clk cycles per millisecond (50 MHz system clock).
// - DELAY_MS      500    Hold time before the first auto-repeat strobe.
// - PERIOD_MS     66     Interval between later auto-repeat strobes (~15 Hz).
// PORTS
// - Clk       in   1   System clock. Every register is rising-edge triggered.
// - Reset_n   in   1   Reset, asynchronous and active-low.
// - md_in     in   7   ASCII keycode from the encoder.
// - kstrb     in   1   One-Clk pulse from the encoder: a new key has been pressed.
// - akd       in   1   Any-key-down level from the encoder.
// - rept_en   in   1   Auto-repeat enable.
// - addr      in   16  CPU address bus.
// - rw        in   1   1 = read, 0 = write.
// - bus_en    in   1   One-Clk qualifier per CPU bus cycle.
// - kbd_sel   out  1   addr is in $C000-$C01F (combinational).
// - data_out  out  8   Read data (combinational; valid whenever kbd_sel = 1).
// - strobe    out  1   Keyboard strobe flag (debug/LED).
// BEHAVIOUR
// - Reset (async, Reset_n = 0):
//   - latch = 7'h00, strobe = 0, FSM = IDLE, ms prescaler = 0, ms counter = 0.
//   - data_out / kbd_sel then follow addr combinationally.
// - Read data:
//   - addr[15:4] = 12'hC00: data_out = {strobe, latch}.
//   - addr[15:4] = 12'hC01: data_out = {akd, latch}.
//   - Otherwise data_out = 8'h00.
//   - Value reflects register state before this Clk edge; read has zero latency.
// - Strobe clear:
//   - bus_en = 1 and addr[15:4] = 12'hC01, read or write, clears strobe at the next edge.
// - Strobe set (priority over clear in the same cycle):
//   - kstrb = 1: latch <= md_in, strobe <= 1.
//   - Repeat event: strobe <= 1, latch unchanged.
//   - If kstrb and clear coincide, the result is strobe = 1 with the new key.
// - ms prescaler: 1-cycle ms_tick every TICKS_PER_MS Clks. Free-running. Only the ms counter uses it.
// - FSM states: IDLE, DELAY, REPEAT.
//   - Any state, kstrb = 1: go to DELAY, ms counter = 0. A new key restarts the delay.
//   - IDLE: wait for kstrb.
//   - DELAY:
//     - akd = 0: go to IDLE.
//     - ms_tick: counter + 1. When counter + 1 = DELAY_MS with rept_en = 1: repeat event, counter = 0, go to REPEAT.
//     - With rept_en = 0: hold at DELAY_MS (saturate) and stay in DELAY. No repeat.
//   - REPEAT:
//     - akd = 0 or rept_en = 0: go to IDLE.
//     - ms_tick: counter + 1. When counter + 1 = PERIOD_MS: repeat event, counter = 0.
// - ms counter width: $clog2(max(DELAY_MS, PERIOD_MS) + 1). Never wraps past its terminal value.
// - Reset mid-hold aborts the repeat immediately. A held key after reset does not strobe until a fresh kstrb.
// - Writes to $C000-$C00F have no effect.
// STRUCTURE
// - Shared package apple2_pkg:
//   - KBD_PAGE = 12'hC00, KBDSTRB_PAGE = 12'hC01.
//   - typedef enum logic [1:0] {KR_IDLE, KR_DELAY, KR_REPEAT} kbd_rpt_state_t.
// - One sub-module, ms_tick_gen #(TICKS_PER_MS):
//   - Ports: Clk, Reset_n, tick.
//   - Also reused later by the paddle timer.
// - Top level holds the latch, strobe, FSM and bus decode.
// TESTING
// - Bench parameters: TICKS_PER_MS = 4, DELAY_MS = 3, PERIOD_MS = 2.
// - Reset: Reset_n low mid-REPEAT, async -> strobe = 0, latch = 0; read $C000 = 8'h00 with no Clk edge needed.
// - Key latch: md_in = 7'h41, kstrb pulse -> next cycle read $C000 = 8'hC1; read $C010 with akd = 1 = 8'hC1, then $C000 = 8'h41.
// - Clear/set race: kstrb (md_in = 7'h42) and bus_en write to $C015 in the same cycle -> $C000 = 8'hC2.
// - Auto-repeat, rept_en = 1, akd held: first re-strobe exactly 12 Clks after kstrb, then every 8 Clks (+/- prescaler phase of 3 Clks).
//   - Each re-strobe is visible after a $C010 clear. Drop akd -> no further strobes.
// - rept_en = 0, key held 100 Clks: exactly one strobe; FSM stays in DELAY.
// - Second key during REPEAT: kstrb with md_in = 7'h5A -> latch = 7'h5A; the next repeat comes after the full 12-Clk delay, not 8.

Source files
------------

// File: rtl/apple2_pkg.sv
// Shared Apple II peripheral definitions: soft-switch pages and keyboard repeat states.
package apple2_pkg;

  localparam logic [11:0] KBD_PAGE     = 12'hC00;
  localparam logic [11:0] KBDSTRB_PAGE = 12'hC01;

  typedef enum logic [1:0] {KR_IDLE, KR_DELAY, KR_REPEAT} kbd_rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICKS_PER_MS clocks.
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_MS - 1);

  logic [PW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Count up and wrap on the tick cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/apple2_kbd_latch.sv
// Apple II keyboard latch: keycode + strobe at $C000, strobe clear at $C010,
// and IIe-style auto-repeat driven by a millisecond prescaler.
module apple2_kbd_latch
  import apple2_pkg::*;
#(
  parameter int TICKS_PER_MS = 50000,
  parameter int DELAY_MS     = 500,
  parameter int PERIOD_MS    = 66
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [6:0]  md_in,
  input  logic        kstrb,
  input  logic        akd,
  input  logic        rept_en,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic        bus_en,
  output logic        kbd_sel,
  output logic [7:0]  data_out,
  output logic        strobe
);

  localparam int CNT_MAX = max_int(DELAY_MS, PERIOD_MS);
  localparam int CW      = $clog2(CNT_MAX + 1);
  // One extra bit so cnt+1 can never alias back to zero at the terminal value.
  localparam logic [CW:0] DLY_V = (CW+1)'(DELAY_MS);
  localparam logic [CW:0] PER_V = (CW+1)'(PERIOD_MS);

  logic           ms_tick;
  kbd_rpt_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW:0]    cnt_inc;
  logic           rpt_evt;
  logic [6:0]     latch_q;
  logic           strobe_q;
  logic [11:0]    page;
  logic           clr;
  logic           addr_unused;

  ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_ms_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (ms_tick)
  );

  // Low address nibble and direction do not matter: the whole page decodes alike.
  assign addr_unused = &{1'b0, addr[3:0], rw};

  assign page    = addr[15:4];
  assign kbd_sel = (page == KBD_PAGE) || (page == KBDSTRB_PAGE);
  assign clr     = bus_en && (page == KBDSTRB_PAGE);
  assign strobe  = strobe_q;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  // Zero-latency read mux from current register state.
  always_comb begin
    data_out = 8'h00;
    if (page == KBD_PAGE)          data_out = {strobe_q, latch_q};
    else if (page == KBDSTRB_PAGE) data_out = {akd, latch_q};
  end

  // Repeat FSM next state; a fresh key always restarts the initial delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_evt = 1'b0;
    if (kstrb) begin
      state_d = KR_DELAY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        KR_IDLE: ;
        KR_DELAY: begin
          if (!akd) begin
            state_d = KR_IDLE;
            cnt_d   = '0;
          end else if (ms_tick) begin
            if (cnt_inc >= DLY_V) begin
              if (rept_en) begin
                rpt_evt = 1'b1;
                cnt_d   = '0;
                state_d = KR_REPEAT;
              end else begin
                // Park at the terminal count until the key is released.
                cnt_d = DLY_V[CW-1:0];
              end
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end
        end
        KR_REPEAT: begin
          if (!akd || !rept_en) begin
            state_d = KR_IDLE;
            cnt_d   = '0;
          end else if (ms_tick) begin
            if (cnt_inc >= PER_V) begin
              rpt_evt = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end
        end
        default: begin
          state_d = KR_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and ms counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= KR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Keycode latch and strobe flag; setting wins over a same-cycle clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      latch_q  <= 7'h00;
      strobe_q <= 1'b0;
    end else if (kstrb) begin
      latch_q  <= md_in;
      strobe_q <= 1'b1;
    end else if (rpt_evt) begin
      strobe_q <= 1'b1;
    end else if (clr) begin
      strobe_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apple2_kbd_latch.sv
// Directed bench for apple2_kbd_latch with a shrunken ms prescaler.
module tb_apple2_kbd_latch;
  import apple2_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [6:0]  md_in = '0;
  logic        kstrb = 1'b0;
  logic        akd = 1'b0;
  logic        rept_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw = 1'b1;
  logic        bus_en = 1'b0;
  logic        kbd_sel;
  logic [7:0]  data_out;
  logic        strobe;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  apple2_kbd_latch #(.TICKS_PER_MS(4), .DELAY_MS(3), .PERIOD_MS(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .md_in(md_in), .kstrb(kstrb), .akd(akd),
    .rept_en(rept_en), .addr(addr), .rw(rw), .bus_en(bus_en),
    .kbd_sel(kbd_sel), .data_out(data_out), .strobe(strobe)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse kstrb for one edge; tk = edge count of the sampling edge.
  task automatic pulse_key(input logic [6:0] code, output int tk);
    @(negedge Clk);
    md_in = code; kstrb = 1'b1;
    @(negedge Clk);
    kstrb = 1'b0;
    tk = cyc;
  endtask

  // One bus cycle touching $C010 (clears strobe at that edge).
  task automatic clear_strobe();
    @(negedge Clk);
    addr = 16'hC010; rw = 1'b1; bus_en = 1'b1;
    @(negedge Clk);
    bus_en = 1'b0; addr = 16'hC000;
  endtask

  // Wait (bounded) for strobe to rise; t = edge count that set it.
  task automatic wait_strobe(input int lim, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge Clk);
      if (strobe) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic read_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
    addr = a; #1;
    n_chk++;
    if (data_out !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, data_out, exp);
    end
  endtask

  task automatic test_reset;
    #1;
    n_chk++;
    if (strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
    read_chk("reset_c000", 16'hC000, 8'h00);
    n_chk++;
    if (kbd_sel !== 1'b1) begin n_fail++; $display("FAIL sel_c000: got %b expected 1", kbd_sel); end
    addr = 16'h1234; #1;
    n_chk++;
    if (kbd_sel !== 1'b0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL sel_other: got sel=%b data=%h expected 0/00", kbd_sel, data_out);
    end
    @(negedge Clk); Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_key_latch;
    int tk;
    akd = 1'b1; rept_en = 1'b0;
    pulse_key(7'h41, tk);
    read_chk("latch_c000", 16'hC000, 8'hC1);
    read_chk("latch_c010_akd", 16'hC010, 8'hC1);
    clear_strobe();
    read_chk("latch_cleared", 16'hC000, 8'h41);
  endtask

  task automatic test_race;
    @(negedge Clk);
    md_in = 7'h42; kstrb = 1'b1; addr = 16'hC015; rw = 1'b0; bus_en = 1'b1;
    @(negedge Clk);
    kstrb = 1'b0; bus_en = 1'b0; rw = 1'b1;
    read_chk("race_c000", 16'hC000, 8'hC2);
    // Writing the KBD page must not disturb anything.
    @(negedge Clk);
    addr = 16'hC003; rw = 1'b0; bus_en = 1'b1;
    @(negedge Clk);
    bus_en = 1'b0; rw = 1'b1;
    read_chk("write_c000_noeffect", 16'hC000, 8'hC2);
    akd = 1'b0;
    repeat (2) @(negedge Clk);
    clear_strobe();
  endtask

  task automatic test_auto_repeat;
    int tk, t1, t2, t3, tx;
    bit ok;
    akd = 1'b1; rept_en = 1'b1;
    pulse_key(7'h43, tk);
    clear_strobe();
    wait_strobe(40, t1, ok);
    n_chk++;
    if (!ok || (t1 - tk) < 9 || (t1 - tk) > 12) begin
      n_fail++; $display("FAIL rpt_first: ok=%0b delay=%0d expected 9..12", ok, t1 - tk);
    end
    clear_strobe();
    wait_strobe(40, t2, ok);
    n_chk++;
    if (!ok || (t2 - t1) != 8) begin
      n_fail++; $display("FAIL rpt_second: ok=%0b gap=%0d expected 8", ok, t2 - t1);
    end
    clear_strobe();
    wait_strobe(40, t3, ok);
    n_chk++;
    if (!ok || (t3 - t2) != 8) begin
      n_fail++; $display("FAIL rpt_third: ok=%0b gap=%0d expected 8", ok, t3 - t2);
    end
    read_chk("rpt_latch_kept", 16'hC000, 8'hC3);
    clear_strobe();
    akd = 1'b0;
    wait_strobe(40, tx, ok);
    n_chk++;
    if (ok) begin n_fail++; $display("FAIL rpt_release: strobe at edge %0d expected none", tx); end
  endtask

  task automatic test_no_repeat;
    int tk, tx;
    bit ok;
    akd = 1'b1; rept_en = 1'b0;
    pulse_key(7'h44, tk);
    clear_strobe();
    wait_strobe(100, tx, ok);
    n_chk++;
    if (ok) begin n_fail++; $display("FAIL norpt_strobe: strobe at edge %0d expected none", tx); end
    n_chk++;
    if (dut.state_q !== KR_DELAY) begin
      n_fail++; $display("FAIL norpt_state: got %0d expected %0d", dut.state_q, KR_DELAY);
    end
    read_chk("norpt_latch", 16'hC000, 8'h44);
    akd = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_second_key;
    int tk, t1, t2, tk2, tn;
    bit ok;
    akd = 1'b1; rept_en = 1'b1;
    pulse_key(7'h41, tk);
    clear_strobe();
    wait_strobe(40, t1, ok);
    clear_strobe();
    wait_strobe(40, t2, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL k2_enter_repeat: no repeat strobe expected one"); end
    clear_strobe();
    pulse_key(7'h5A, tk2);
    read_chk("k2_latch", 16'hC000, 8'hDA);
    clear_strobe();
    wait_strobe(40, tn, ok);
    n_chk++;
    if (!ok || (tn - tk2) < 9 || (tn - tk2) > 12) begin
      n_fail++; $display("FAIL k2_full_delay: ok=%0b delay=%0d expected 9..12", ok, tn - tk2);
    end
  endtask

  // Entered while repeating with strobe set.
  task automatic test_reset_mid_repeat;
    int tx;
    bit ok;
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    addr = 16'hC000;
    #1;
    n_chk++;
    if (strobe !== 1'b0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got strobe=%b data=%h expected 0/00", strobe, data_out);
    end
    @(negedge Clk); Reset_n = 1'b1;
    wait_strobe(40, tx, ok);
    n_chk++;
    if (ok) begin n_fail++; $display("FAIL held_after_reset: strobe at edge %0d expected none", tx); end
    akd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key_latch();
    test_race();
    test_auto_repeat();
    test_no_repeat();
    test_second_key();
    test_reset_mid_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
